// File: rtl/mkds_cmd_master.sv
// Command master for the MKDS decoder: turns host requests into timed
// 16-bit command words (setup, RW/RD strobe, hold) or a CLR pulse.
module mkds_cmd_master #(
  parameter int unsigned STROBE_LEN = 4,
  parameter int unsigned HOLD_LEN   = 2,
  parameter int unsigned CLR_LEN    = 3
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_clr,
  input  logic [4:0]  req_addr,
  input  logic [7:0]  req_data,
  output logic [15:0] data_out,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] CLEAR  = 3'd4;

  localparam logic [3:0]  STROBE_CNT = 4'(STROBE_LEN);
  localparam logic [3:0]  HOLD_CNT   = 4'(HOLD_LEN);
  localparam logic [3:0]  CLEAR_CNT  = 4'(CLR_LEN);
  localparam logic [4:0]  MAX_ADDR   = 5'd19;
  localparam logic [15:0] CLR_WORD   = 16'h8000;
  localparam int          STB_BIT    = 14;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] data_d;
  logic        done_d, err_d, ready_d;
  logic        accept;

  // req_ready is a register, so accept never depends combinationally on itself.
  assign accept = req_valid & req_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred on any path.
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_out;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_clr) begin
            state_d = CLEAR;
            cnt_d   = CLEAR_CNT;
            data_d  = CLR_WORD;
          end else if (req_addr <= MAX_ADDR) begin
            state_d = SETUP;
            data_d  = {3'b000, req_addr, req_data};
          end else begin
            err_d   = 1'b1;
          end
        end
      end

      SETUP: begin
        state_d         = STROBE;
        cnt_d           = STROBE_CNT;
        data_d[STB_BIT] = 1'b1;
      end

      // Address and payload bits are never touched here, only bit 14.
      STROBE: begin
        if (cnt_q == 4'd1) begin
          state_d         = HOLD;
          cnt_d           = HOLD_CNT;
          data_d[STB_BIT] = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      HOLD: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          data_d  = 16'h0000;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      CLEAR: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          data_d  = 16'h0000;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        data_d  = 16'h0000;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (CLR) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      data_out  <= 16'h0000;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_out  <= data_d;
      done      <= done_d;
      err       <= err_d;
      req_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_mkds_cmd_master.sv
// Bench for mkds_cmd_master: two instances (default timing and 15/1/1 timing)
// checked cycle by cycle against command traces built from the timing rules.
module tb_mkds_cmd_master;

  logic              CLK = 1'b0;
  logic              CLR;
  logic [1:0]        v;
  logic              req_clr;
  logic [4:0]        req_addr;
  logic [7:0]        req_data;
  logic [1:0]        rdy, done, err;
  logic [1:0][15:0]  dout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc0[$];

  always #5 CLK = ~CLK;

  mkds_cmd_master u0 (
    .CLK(CLK), .CLR(CLR), .req_valid(v[0]), .req_ready(rdy[0]),
    .req_clr(req_clr), .req_addr(req_addr), .req_data(req_data),
    .data_out(dout[0]), .done(done[0]), .err(err[0])
  );

  mkds_cmd_master #(.STROBE_LEN(15), .HOLD_LEN(1), .CLR_LEN(1)) u1 (
    .CLK(CLK), .CLR(CLR), .req_valid(v[1]), .req_ready(rdy[1]),
    .req_clr(req_clr), .req_addr(req_addr), .req_data(req_data),
    .data_out(dout[1]), .done(done[1]), .err(err[1])
  );

  // Accept edges of unit 0, for measuring the back-to-back period.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (v[0] === 1'b1 && rdy[0] === 1'b1 && CLR === 1'b0) acc0.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int slen(input int u); return (u == 1) ? 15 : 4; endfunction
  function automatic int hlen(input int u); return (u == 1) ? 1 : 2;  endfunction
  function automatic int clen(input int u); return (u == 1) ? 1 : 3;  endfunction

  // {ready, done, err, data_out}
  function automatic logic [18:0] obs(input int u);
    return {rdy[u], done[u], err[u], dout[u]};
  endfunction

  task automatic check(input string tag, input logic [18:0] o, input logic [18:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic scramble();
    req_clr  = 1'($urandom);
    req_addr = 5'($urandom);
    req_data = 8'($urandom);
  endtask

  task automatic wait_ready(input int u);
    for (int i = 0; i < 64 && rdy[u] !== 1'b1; i++) @(negedge CLK);
    check("ready_wait", {18'd0, rdy[u]}, 19'd1);
  endtask

  // Called at the first negedge after the accept edge; returns at the
  // done cycle (or after the err pulse has cleared).
  task automatic expect_cmd(input int u, input logic c, input logic [4:0] a,
                            input logic [7:0] d, input bit jit);
    logic [15:0] base;
    logic [15:0] words[$];
    base = {3'b000, a, d};
    if (c) begin
      repeat (clen(u)) words.push_back(16'h8000);
    end else if (a <= 5'd19) begin
      words.push_back(base);
      repeat (slen(u)) words.push_back(base | 16'h4000);
      repeat (hlen(u)) words.push_back(base);
    end
    if (words.size() == 0) begin
      check($sformatf("u%0d_err_pulse a=%0d", u, a), obs(u), {3'b101, 16'h0000});
      if (jit) scramble();
      @(negedge CLK);
      check($sformatf("u%0d_err_clear", u), obs(u), {3'b100, 16'h0000});
    end else begin
      foreach (words[i]) begin
        check($sformatf("u%0d_busy%0d a=%0d c=%0d", u, i, a, c), obs(u), {3'b000, words[i]});
        if (jit) scramble();
        @(negedge CLK);
      end
      check($sformatf("u%0d_done a=%0d c=%0d", u, a, c), obs(u), {3'b110, 16'h0000});
    end
  endtask

  task automatic issue(input int u, input logic c, input logic [4:0] a,
                       input logic [7:0] d, input bit jit);
    wait_ready(u);
    req_clr  = c;
    req_addr = a;
    req_data = d;
    v[u]     = 1'b1;
    @(negedge CLK);
    v[u] = 1'b0;
    expect_cmd(u, c, a, d, jit);
    if (c || a <= 5'd19) begin
      @(negedge CLK);
      check($sformatf("u%0d_after_done", u), obs(u), {3'b100, 16'h0000});
    end
  endtask

  initial begin
    logic [4:0] a;
    logic [7:0] d;
    logic       c;

    CLR = 1'b1; v = 2'b00; req_clr = 1'b0; req_addr = 5'd0; req_data = 8'd0;
    repeat (3) @(negedge CLK);
    check("u0_reset", obs(0), {3'b000, 16'h0000});
    check("u1_reset", obs(1), {3'b000, 16'h0000});

    // A request while CLR is high is ignored.
    v[0] = 1'b1; req_addr = 5'd5; req_data = 8'h11;
    @(negedge CLK);
    check("u0_req_in_reset", obs(0), {3'b000, 16'h0000});
    v[0] = 1'b0; CLR = 1'b0;
    @(negedge CLK);
    check("u0_release", obs(0), {3'b100, 16'h0000});
    check("u1_release", obs(1), {3'b100, 16'h0000});

    // Directed: write, clear, rejected addresses.
    issue(0, 1'b0, 5'd5,  8'hA5, 1'b1);
    issue(0, 1'b1, 5'd3,  8'hFF, 1'b1);
    issue(0, 1'b0, 5'd20, 8'h5A, 1'b1);
    issue(0, 1'b0, 5'd31, 8'h01, 1'b1);

    // Back-to-back: valid held high, second accept on the done cycle.
    wait_ready(0);
    req_clr = 1'b0; req_addr = 5'd19; req_data = 8'h3C; v[0] = 1'b1;
    @(negedge CLK);
    req_addr = 5'd16; req_data = 8'hC3;
    expect_cmd(0, 1'b0, 5'd19, 8'h3C, 1'b0);
    @(negedge CLK);
    v[0] = 1'b0;
    expect_cmd(0, 1'b0, 5'd16, 8'hC3, 1'b1);
    @(negedge CLK);
    check("u0_b2b_after_done", obs(0), {3'b100, 16'h0000});
    check("u0_b2b_period", 19'(acc0[$] - acc0[$-1]), 19'd8);

    // Reset during the second strobe cycle aborts the command.
    wait_ready(0);
    req_clr = 1'b0; req_addr = 5'd9; req_data = 8'h77; v[0] = 1'b1;
    @(negedge CLK);
    v[0] = 1'b0;
    check("u0_abort_setup", obs(0), {3'b000, 16'h0977});
    @(negedge CLK);
    check("u0_abort_stb1", obs(0), {3'b000, 16'h4977});
    @(negedge CLK);
    check("u0_abort_stb2", obs(0), {3'b000, 16'h4977});
    CLR = 1'b1;
    @(negedge CLK);
    check("u0_abort_reset", obs(0), {3'b000, 16'h0000});
    v[0] = 1'b1; req_addr = 5'd7;
    @(negedge CLK);
    check("u0_abort_held", obs(0), {3'b000, 16'h0000});
    v[0] = 1'b0; CLR = 1'b0;
    @(negedge CLK);
    check("u0_abort_release", obs(0), {3'b100, 16'h0000});
    @(negedge CLK);
    check("u0_abort_no_done", obs(0), {3'b100, 16'h0000});
    issue(0, 1'b0, 5'd12, 8'h42, 1'b1);

    // Long strobe / minimum hold and minimum clear timing.
    issue(1, 1'b0, 5'd17, 8'h9E, 1'b1);
    issue(1, 1'b1, 5'd0,  8'h00, 1'b1);
    issue(1, 1'b0, 5'd25, 8'h10, 1'b1);

    // Randomized commands on both units.
    for (int i = 0; i < 14; i++) begin
      c = ($urandom_range(0, 3) == 0);
      a = 5'($urandom);
      d = 8'($urandom);
      issue((i % 3 == 2) ? 1 : 0, c, a, d, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
